interrupt_controller: RTL
=========================

# interrupt_controller

Interrupt front-end between the MotherBoard's external `i_interruption[4:0]` pins and core0's exception logic. It synchronizes the five asynchronous lines, detects edges or levels per line, and holds maskable pending state. It presents one prioritized request to the core with a request/acknowledge handshake and tracks the in-service interrupt until the core executes `eret`.

## Interface
- `N_IRQ`, 5, number of interrupt lines (max 8)
- `SYNC_STAGES`, 2, synchronizer flops per line (≥2)

- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-low reset
- `i_interruption`  in  N_IRQ  raw external interrupt lines, asynchronous
- `i_cfg_we`  in  1  config write strobe
- `i_cfg_addr`  in  2  register select: 0 MASK, 1 EDGE, 2 PENDING, 3 STATUS
- `i_cfg_wdata`  in  32  write data (low N_IRQ bits used)
- `o_cfg_rdata`  out  32  combinational read of selected register, upper bits zero
- `o_irq_req`  out  1  interrupt request to core
- `o_irq_cause`  out  3  index of requested/in-service line
- `i_irq_ack`  in  1  core accepts request (one-cycle pulse)
- `i_eret`  in  1  core retired `eret`; ends service

## Operation
- Registers: MASK (reset 0, all masked), EDGE (reset all 1s; 1 = rising-edge, 0 = level), PENDING (reset 0; write-1-to-clear), STATUS read-only = {28'b0, in_service, cause}.
- Edge line: PENDING bit set on synchronized rising edge; cleared by W1C or by ack of that line. Level line: PENDING bit mirrors synchronized level; W1C has no effect.
- Set beats clear in the same cycle (edge + W1C, edge + ack on same line).
- Eligible = PENDING & MASK; priority fixed, lowest index wins.
- FSM states IDLE, REQUEST, IN_SERVICE:
  - IDLE: if any eligible, latch winning index into cause → REQUEST.
  - REQUEST: `o_irq_req`=1, cause held stable even if higher-priority line arrives. On `i_irq_ack` → IN_SERVICE, clear PENDING bit of cause if edge line. If latched line stops being eligible (masked, level drop, W1C) before ack → IDLE (withdraw); ack in same cycle as withdrawal wins.
  - IN_SERVICE: no request (no nesting); cause held. On `i_eret` → IDLE.
- `i_irq_ack` outside REQUEST and `i_eret` outside IN_SERVICE ignored.
- Outputs at reset: `o_irq_req`=0, `o_irq_cause`=0, state IDLE, synchronizers 0.

## Timing
- Raw rising edge before clock edge E0: sync stage 1 at E0, stage 2 at E1, PENDING at E2, `o_irq_req` high after E3 (SYNC_STAGES=2; +1 per extra stage).
- `o_irq_req`, `o_irq_cause` registered; drop the cycle after ack or withdrawal.
- After `i_eret` at edge Ek, state IDLE at Ek; next request earliest after Ek+1.
- Config write takes effect on the edge of `i_cfg_we`; reads reflect it the following cycle.
- Asynchronous reset mid-REQUEST or IN_SERVICE returns immediately to IDLE, all registers to reset values; pulses in flight lost.

## Structure
- Package `intc_pkg`: state enum, register address constants, `N_IRQ` default, cause width.
- Sub-module `irq_sync_edge`: per-line SYNC_STAGES synchronizer plus delayed flop, outputs `level` and `rise`; instantiated N_IRQ times.

## Test plan
- Reset defaults: after `reset` low then high, read MASK=0, EDGE=0x1F, PENDING=0, STATUS=0; pulse line 2 → PENDING=0x04, `o_irq_req` stays 0.
- MASK=0x1F, pulse line 3 → `o_irq_req`=1 with cause=3 exactly 4 clocks after pulse; ack → req 0, PENDING=0, STATUS=0x0B; `eret` → STATUS=0.
- Lines 1 and 4 pulsed same cycle → cause=1; during IN_SERVICE line 4 stays pending, no request; after `eret` request with cause=4.
- EDGE=0x1E, line 0 level high → request cause=0; drop line 0 before ack → req withdrawn next cycle, state IDLE.
- Line 2 edge coincident with W1C of bit 2 → PENDING bit 2 remains 1.
- Assert `reset` low during IN_SERVICE → req=0, cause=0, STATUS=0 immediately; late ack/`eret` ignored.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller.
package intc_pkg;

  // Default number of interrupt lines and the architectural maximum.
  localparam int N_IRQ_DEF = 5;
  localparam int MAX_IRQ   = 8;

  // Width of the cause field (enough to index MAX_IRQ lines).
  localparam int CAUSE_W = 3;

  // Configuration register map.
  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_EDGE    = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  // Request handshake state.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_REQUEST    = 2'd1,
    ST_IN_SERVICE = 2'd2
  } state_e;

  // Fixed priority: the lowest set index wins. Returns 0 when nothing is set.
  function automatic logic [CAUSE_W-1:0] lowest_set(input logic [MAX_IRQ-1:0] vec);
    lowest_set = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = CAUSE_W'(i);
    end
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line synchronizer with rising-edge detection. 'level' is the
// synchronized line; 'rise' is high for one cycle after it goes 0 -> 1.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_line,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw line through the synchronizer and keep one delayed copy.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_line};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt front-end: synchronizes external lines, keeps maskable pending
// state and drives one prioritized request with an ack / eret handshake.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int N_IRQ       = N_IRQ_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_IRQ-1:0]   i_interruption,
  input  logic               i_cfg_we,
  input  logic [1:0]         i_cfg_addr,
  input  logic [31:0]        i_cfg_wdata,
  output logic [31:0]        o_cfg_rdata,
  output logic               o_irq_req,
  output logic [CAUSE_W-1:0] o_irq_cause,
  input  logic               i_irq_ack,
  input  logic               i_eret
);

  logic [N_IRQ-1:0]   line_level;
  logic [N_IRQ-1:0]   line_rise;
  logic [N_IRQ-1:0]   mask_q, mask_d;
  logic [N_IRQ-1:0]   edge_q, edge_d;
  logic [N_IRQ-1:0]   pending_q, pending_d;
  logic [N_IRQ-1:0]   eligible;
  logic [N_IRQ-1:0]   cause_onehot;
  logic [N_IRQ-1:0]   w1c;
  logic [N_IRQ-1:0]   ack_clr;
  state_e             state_q, state_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               ack_take;
  logic               in_service;
  logic               unused_wdata;

  // Only the low N_IRQ bits of the write data carry meaning.
  assign unused_wdata = ^i_cfg_wdata[31:N_IRQ];

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk    (clk),
      .reset  (reset),
      .i_line (i_interruption[g]),
      .level  (line_level[g]),
      .rise   (line_rise[g])
    );
  end

  assign eligible     = pending_q & mask_q;
  assign cause_onehot = N_IRQ'(1) << cause_q;
  assign ack_take     = (state_q == ST_REQUEST) && i_irq_ack;
  assign in_service   = (state_q == ST_IN_SERVICE);

  // Config writes and pending update; a new edge beats any clear in the same cycle.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    mask_d  = mask_q;
    edge_d  = edge_q;
    w1c     = '0;
    ack_clr = '0;
    if (i_cfg_we) begin
      unique case (i_cfg_addr)
        ADDR_MASK:    mask_d = i_cfg_wdata[N_IRQ-1:0];
        ADDR_EDGE:    edge_d = i_cfg_wdata[N_IRQ-1:0];
        ADDR_PENDING: w1c    = i_cfg_wdata[N_IRQ-1:0];
        default:      ;
      endcase
    end
    if (ack_take) ack_clr = cause_onehot;
    pending_d = (edge_q & (line_rise | (pending_q & ~(w1c | ack_clr))))
              | (~edge_q & line_level);
  end

  // Configuration and pending registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q    <= '0;
      edge_q    <= '1;
      pending_q <= '0;
    end else begin
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      pending_q <= pending_d;
    end
  end

  // Handshake state register with the latched cause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Next state: latch the winner, hold it, withdraw if it loses eligibility.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          state_d = ST_REQUEST;
          cause_d = lowest_set(MAX_IRQ'(eligible));
        end
      end
      ST_REQUEST: begin
        if (i_irq_ack) begin
          state_d = ST_IN_SERVICE;
        end else if (!(|(eligible & cause_onehot))) begin
          state_d = ST_IDLE;
          cause_d = '0;
        end
      end
      ST_IN_SERVICE: begin
        if (i_eret) begin
          state_d = ST_IDLE;
          cause_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cause_d = '0;
      end
    endcase
  end

  // Outputs decoded straight from registered state.
  always_comb begin
    o_irq_req   = (state_q == ST_REQUEST);
    o_irq_cause = cause_q;
  end

  // Register readback; upper bits read as zero.
  always_comb begin
    o_cfg_rdata = '0;
    unique case (i_cfg_addr)
      ADDR_MASK:    o_cfg_rdata[N_IRQ-1:0] = mask_q;
      ADDR_EDGE:    o_cfg_rdata[N_IRQ-1:0] = edge_q;
      ADDR_PENDING: o_cfg_rdata[N_IRQ-1:0] = pending_q;
      ADDR_STATUS:  o_cfg_rdata[CAUSE_W:0] = {in_service, cause_q};
      default:      ;
    endcase
  end

endmodule
